// File: rtl/red_tree_collector.sv
// red_tree_collector: drains one snapshot of FAN reduction-tree node sums
// onto a valid/ready stream, lowest valid node index first, root last.

// One tree node's storage: a captured sum and its pending flag.
module red_tree_collector_node #(
  parameter int S = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [S-1:0] ld_sum,
  input  logic         ld_vld,
  input  logic         clr,
  output logic [S-1:0] sum,
  output logic         pend
);

  // Capture on snapshot accept; drop the pending flag once its beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      pend <= 1'b0;
    end else if (load) begin
      sum  <= ld_sum;
      pend <= ld_vld;
    end else if (clr) begin
      pend <= 1'b0;
    end
  end

endmodule

module red_tree_collector #(
  parameter int N    = 32,
  parameter int W    = 8,
  parameter int S    = W + $clog2(N),
  parameter int I    = $clog2(N),
  parameter int FC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-2:0][S-1:0]     id_sums,
  input  logic [N-2:0]            id_valids,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [S-1:0]            out_sum,
  output logic [I-1:0]            out_idx,
  output logic                    out_last,
  output logic [FC_W-1:0]         frame_count
);

  localparam int M = N - 1;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state;
  logic [M-1:0]        pend;
  logic [M-1:0][S-1:0] sum_q;
  logic [M-1:0]        pick;
  logic [M-1:0]        clr;
  logic                load;
  logic                single;
  logic                take;

  // Snapshot accepted only while idle; input data ignored otherwise.
  assign load = (state == IDLE) && in_valid;
  assign take = (state == DRAIN) && out_ready;

  // Isolate the lowest pending bit; that node is the current beat.
  assign pick   = pend & ~(pend - M'(1));
  assign single = (pend != '0) && ((pend & (pend - M'(1))) == '0);
  assign clr    = take ? pick : '0;

  genvar g;
  generate
    for (g = 0; g < M; g++) begin : g_node
      red_tree_collector_node #(.S(S)) u_node (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .ld_sum (id_sums[g]),
        .ld_vld (id_valids[g]),
        .clr    (clr[g]),
        .sum    (sum_q[g]),
        .pend   (pend[g])
      );
    end
  endgenerate

  // Priority encode the lowest pending node index.
  always_comb begin
    out_idx = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (pend[i]) out_idx = I'(i);
    end
  end

  assign out_sum   = sum_q[out_idx];
  assign out_valid = (state == DRAIN);
  assign in_ready  = (state == IDLE);
  assign out_last  = (state == DRAIN) && single;

  // Frame sequencing and completed-frame counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (id_valids != '0) state <= DRAIN;
          else                 frame_count <= frame_count + 1'b1;
        end
        DRAIN: if (out_ready && single) begin
          state       <= IDLE;
          frame_count <= frame_count + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_tree_collector.sv
// Bench for red_tree_collector: directed table, corner sequences and random
// frames checked against a queue-based reference of the expected beats.
module tb_red_tree_collector;

  localparam int N    = 32;
  localparam int W    = 8;
  localparam int S    = W + $clog2(N);
  localparam int I    = $clog2(N);
  localparam int FC_W = 16;
  localparam int M    = N - 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [M-1:0][S-1:0] id_sums;
  logic [M-1:0]        id_valids;
  logic                out_valid;
  logic                out_ready;
  logic [S-1:0]        out_sum;
  logic [I-1:0]        out_idx;
  logic                out_last;
  logic [FC_W-1:0]     frame_count;

  int              n_cmp = 0;
  int              n_err = 0;
  logic [FC_W-1:0] fc_exp;

  red_tree_collector #(.N(N), .W(W), .FC_W(FC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .id_sums     (id_sums),
    .id_valids   (id_valids),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: expected beats are the valid node indices in ascending order.
  // mode 0: ready always, 1: ready toggles 1,0,1,0..., 2: random ready.
  task automatic run_frame(input logic [M-1:0][S-1:0] sums, input logic [M-1:0] vld,
                           input int mode, input bit keep);
    int             qi[$];
    logic [S-1:0]   qs[$];
    int             t;
    logic           rdy;
    for (int i = 0; i < M; i++) begin
      if (vld[i]) begin
        qi.push_back(i);
        qs.push_back(sums[i]);
      end
    end
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    id_sums   = sums;
    id_valids = vld;
    out_ready = 1'b0;
    step();
    if (keep) begin
      for (int i = 0; i < M; i++) id_sums[i] = S'($urandom);
      id_valids = M'($urandom) | M'(1);
    end else begin
      in_valid = 1'b0;
    end
    if (qi.size() == 0) begin
      fc_exp++;
      chk("empty_out_valid", 32'(out_valid), 32'd0);
      chk("empty_in_ready", 32'(in_ready), 32'd1);
      chk("empty_frame_count", 32'(frame_count), 32'(fc_exp));
      return;
    end
    t = 0;
    while (qi.size() > 0 && t < 200) begin
      chk("beat_valid", 32'(out_valid), 32'd1);
      chk("beat_in_ready", 32'(in_ready), 32'd0);
      chk("beat_idx", 32'(out_idx), 32'(qi[0]));
      chk("beat_sum", 32'(out_sum), 32'(qs[0]));
      chk("beat_last", 32'(out_last), 32'(qi.size() == 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (t % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      step();
      if (rdy) begin
        void'(qi.pop_front());
        void'(qs.pop_front());
      end
      t++;
    end
    chk("drain_timeout_left", 32'(qi.size()), 32'd0);
    fc_exp++;
    out_ready = 1'b0;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_frame_count", 32'(frame_count), 32'(fc_exp));
  endtask

  typedef struct {
    logic [I-1:0] idx;
    logic [S-1:0] sum;
  } vec_t;

  vec_t                vecs[5];
  logic [M-1:0][S-1:0] sums;
  logic [M-1:0]        vld;
  logic [FC_W-1:0]     npre;

  initial begin
    vecs[0] = '{idx: 5'd5,  sum: 13'h1A3};
    vecs[1] = '{idx: 5'd0,  sum: 13'h001};
    vecs[2] = '{idx: 5'd30, sum: 13'h1FFF};
    vecs[3] = '{idx: 5'd15, sum: 13'h0AA5};
    vecs[4] = '{idx: 5'd1,  sum: 13'h0000};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    id_sums = '0; id_valids = '0;
    fc_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset in the middle of a stalled drain.
    for (int i = 0; i < M; i++) sums[i] = S'($urandom);
    in_valid = 1'b1; id_sums = sums; id_valids = M'(32'hC);
    step();
    in_valid = 1'b0;
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_idx", 32'(out_idx), 32'd2);
    step();
    chk("mid_stall_idx", 32'(out_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mid_rst_no_beat", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Single-node table: one beat in the cycle after accept, then idle.
    foreach (vecs[k]) begin
      for (int i = 0; i < M; i++) sums[i] = S'($urandom);
      sums[vecs[k].idx] = vecs[k].sum;
      chk("tbl_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; id_sums = sums; id_valids = M'(1) << vecs[k].idx;
      step();
      in_valid = 1'b0;
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_idx", 32'(out_idx), 32'(vecs[k].idx));
      chk("tbl_sum", 32'(out_sum), 32'(vecs[k].sum));
      chk("tbl_last", 32'(out_last), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      fc_exp++;
      chk("tbl_in_ready_after", 32'(in_ready), 32'd1);
      chk("tbl_out_valid_after", 32'(out_valid), 32'd0);
      chk("tbl_frame_count", 32'(frame_count), 32'(fc_exp));
    end

    // Ordering under toggling backpressure.
    for (int i = 0; i < M; i++) sums[i] = S'($urandom);
    sums[0] = 13'h003; sums[16] = 13'h007; sums[30] = 13'h1FE0;
    vld = '0; vld[0] = 1'b1; vld[16] = 1'b1; vld[30] = 1'b1;
    run_frame(sums, vld, 1, 1'b0);

    // Empty snapshot.
    run_frame(sums, '0, 0, 1'b0);
    step();
    chk("empty_idle_valid", 32'(out_valid), 32'd0);

    // Full drain with in_valid held high during the drain, then back-to-back.
    for (int i = 0; i < M; i++) sums[i] = S'(i * 3);
    run_frame(sums, '1, 0, 1'b1);
    for (int i = 0; i < M; i++) sums[i] = S'($urandom);
    run_frame(sums, M'($urandom) | M'(32'h4000_0000), 2, 1'b0);

    // Random frames with random backpressure.
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < M; i++) sums[i] = S'($urandom);
      vld = M'($urandom);
      if (f % 3 == 0) vld = vld & M'($urandom);
      if (f % 7 == 0) vld = '0;
      run_frame(sums, vld, 2, f[0]);
    end
    in_valid = 1'b0;
    step();

    // Counter wrap via a run of empty snapshots.
    npre = 16'hFFFF - fc_exp;
    in_valid = 1'b1; id_valids = '0;
    for (int c = 0; c < int'(npre); c++) step();
    in_valid = 1'b0;
    fc_exp = 16'hFFFF;
    chk("wrap_preload", 32'(frame_count), 32'h0000_FFFF);
    run_frame(sums, '0, 0, 1'b0);
    chk("wrap_zero", 32'(frame_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/red_tree_collector.md
Name: red_tree_collector

Overview:
- Consumer-side drain for the FAN reduction tree.
- Takes one snapshot of the tree's N-1 node sums and per-node valid flags over a valid/ready input handshake.
- Serialises every valid node sum onto a valid/ready output stream, tagged with its node index, in ascending node order (level 0 nodes first, root last).
- Feeds the output buffer / writeback path downstream of the adder tree.

Parameters:
- N, 32, number of tree operands; power of 2, N >= 4; tree has N-1 nodes.
- W, 8, operand bit-width.
- S, W + $clog2(N), node sum width; must match the tree's output width.
- I, $clog2(N), node index width; covers nodes 0..N-2.
- FC_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  snapshot available.
- in_ready  output  1  collector can accept a snapshot.
- id_sums  input  (N-1)xS  node sums, packed [N-2:0][S-1:0].
- id_valids  input  N-1  per-node valid flags.
- out_valid  output  1  output beat available.
- out_ready  input  1  downstream accepts the beat.
- out_sum  output  S  sum of the current node.
- out_idx  output  I  node index of the current beat.
- out_last  output  1  final beat of the current snapshot.
- frame_count  output  FC_W  snapshots fully processed; wraps.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - state=IDLE, pending mask=0, sum regs=0, frame_count=0.
  - out_valid=0, out_last=0, out_sum=0, out_idx=0, in_ready=1.
  - Reset mid-drain discards the snapshot with no further beats.
- States: IDLE, DRAIN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1, id_sums is registered into sum regs and id_valids into the pending mask.
  - If id_valids != 0, go to DRAIN.
  - If id_valids == 0, stay IDLE, emit no beats, frame_count+1 in the same edge.
- DRAIN:
  - in_ready=0; in_valid and input data are ignored.
  - out_valid=1.
  - out_idx = lowest set bit of the pending mask; out_sum = sum reg[out_idx].
  - out_last=1 iff exactly one pending bit remains.
  - On out_valid & out_ready: clear that pending bit.
  - If out_last is also set on that beat: go to IDLE and frame_count+1.
  - With out_ready=0: out_sum, out_idx and out_last are held stable; no bit is cleared.
- Latency and throughput:
  - Snapshot accepted at edge k gives first out_valid in cycle k+1.
  - One beat per cycle while out_ready=1.
  - in_ready reasserts in the cycle after the last beat.
  - A new snapshot can be accepted in that cycle, giving one bubble between frames.
- Width rules:
  - out_sum is passed through unmodified with no arithmetic.
  - frame_count wraps modulo 2^FC_W with no saturation.
- The pending mask is only ever cleared bit-by-bit in ascending order.
- Outputs are driven from registers and the stable pending mask; no combinational path from in_valid or id_* to the out_* ports.

Test Plan:
- Reset mid-drain: snapshot with bits 2,3 valid, out_ready=0, drop rst_n for 1 cycle -> out_valid=0 immediately, in_ready=1 after release, frame_count=0, no beat for node 3 ever appears.
- Single node: id_valids=1<<5, id_sums[5]=0x1A3, out_ready=1 -> exactly one beat in cycle k+1 with out_idx=5, out_sum=0x1A3, out_last=1; frame_count=1; in_ready=1 in cycle k+2.
- Ordering with backpressure: valids {0,16,30}, sums 0x003/0x007/0x1FE0, out_ready toggling 1,0,1,0 -> beats idx 0,16,30 in order; data held stable during stalls; out_last only on idx 30.
- Empty snapshot: id_valids=0, in_valid=1 -> in_ready stays 1, out_valid never rises, frame_count increments by 1.
- Full drain: all 31 bits valid, sums[i]=i*3, out_ready=1; in_valid kept high with changed id_sums during DRAIN -> 31 consecutive beats idx 0..30 with sums 0..90, inputs ignored, second snapshot accepted in the cycle after beat 30.
- Counter wrap: preload via 0xFFFF empty snapshots, then one more -> frame_count reads 0x0000.
